mult_16b_seq: RTL
=================

// Module: mult_16b_seq
// PURPOSE
//   Iterative unsigned shift-and-add multiplier: 16b x 16b -> 32b product.
//   Instantiates one cla_16b as its only adder. Each iteration feeds the
//   upper partial product and the multiplicand into the CLA. The CLA sum and
//   carry-out are consumed in the same cycle. Sits in the ALU datapath beside
//   the CLA adder and serves MUL-class operations through a start/done handshake.
// PARAMETERS
//   N      16   operand width; only 16 is supported (the CLA is fixed at 16b)
//   CNT_W  5    iteration counter width, enough to hold 0..N
// PORTS
//   clk      in   1    clock, rising-edge
//   rst_n    in   1    asynchronous active-low reset
//   start    in   1    request; sampled when busy==0
//   a        in   N    multiplicand; captured on an accepted start
//   b        in   N    multiplier; captured on an accepted start
//   busy     out  1    high while the state is RUN
//   done     out  1    one-cycle pulse when product becomes valid
//   product  out  2N   result; held stable from done until the next accepted start
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE, busy=0, done=0, product=0, cnt=0,
//     internal registers cleared. Reset during RUN aborts with no done pulse.
//   - States:
//     - IDLE: start -> RUN. Captures mcand=a, {hi,lo}={N'b0,b}, cnt=0.
//     - RUN: each cycle, if lo[0]: {c,s}=hi+mcand through cla_16b with c_in=0;
//       otherwise {c,s}={1'b0,hi}. Then {hi,lo}<={c,s,lo[N-1:1]} and cnt++.
//       When cnt==N-1, this edge -> DONE.
//     - DONE: done=1, product={hi,lo}.
//       start -> RUN (back-to-back capture); otherwise -> IDLE.
//   - Latency: start accepted at edge E0. RUN runs N cycles. done is high in
//     the cycle after edge E16 (17 cycles start-to-done).
//   - The carry-out of each add is the new MSB of hi. Width is never lost:
//     max product 0xFFFE0001 fits in 2N bits.
//   - start while busy=1 is ignored; a/b are not re-sampled.
//   - product updates only on entry to DONE. During RUN it holds the previous result.
//   - done never asserts in the same cycle as busy.
// CONFIGURATION
//   ZERO_SKIP_EN defined:
//     - On an accepted start with a==0 or b==0: skip RUN and go directly to DONE.
//     - product=0, done is high in the cycle after E0 (latency 1).
//     - Nonzero operands behave as above.
//   ZERO_SKIP_EN undefined:
//     - All operands take the full N-iteration latency, including zeros.
// TESTING
//   1. a=3, b=5, start 1 cycle -> busy 16 cycles; done 1 cycle, 17 cycles after start; product=0x0000000F.
//   2. a=0xFFFF, b=0xFFFF -> product=0xFFFE0001; exercises CLA c_out into hi MSB every iteration.
//   3. Start a=7,b=9; at cycle 5 pulse start with a=2,b=2 -> ignored; product=0x3F at done.
//   4. Start a=0x1234,b=0x5678; drop rst_n at cycle 8 -> immediately busy=0, done=0, product=0;
//      no done pulse afterward. A new start after release yields product=0x06260060.
//   5. start held high across DONE -> second op (a=0x8000,b=2) is captured in the DONE cycle;
//      second done 17 cycles later, product=0x00010000.
//   6. a=0, b=0xABCD:
//      - with ZERO_SKIP_EN: done 1 cycle after start, product=0, busy never high;
//      - without it: 17-cycle latency, product=0.

Source files
------------

// File: rtl/mult_16b_seq.sv
// Iterative unsigned shift-and-add multiplier, 16b x 16b -> 32b, using one
// cla_16b as its only adder. A start/done handshake serves MUL-class ALU ops.
// Optional feature macro: ZERO_SKIP_EN. When it is defined, a zero operand
// finishes in one cycle with product 0.

// 16-bit carry-lookahead adder: 4-bit groups with a second lookahead level.
module cla_16b (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        c_in,
   output logic [15:0] sum,
   output logic        c_out
);

   logic [15:0] p;
   logic [15:0] g;
   logic [3:0]  gp;
   logic [3:0]  gg;
   logic [4:0]  gc;
   logic [15:0] c;

   assign p = a ^ b;
   assign g = a & b;

   // Group propagate/generate for each 4-bit slice.
   always_comb begin
      gp = '0;
      gg = '0;
      for (int k = 0; k < 4; k++) begin
         gp[k] = &p[4*k +: 4];
         gg[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      end
   end

   // Carries into each group, all derived directly from c_in.
   always_comb begin
      gc    = '0;
      gc[0] = c_in;
      gc[1] = gg[0] | (gp[0] & c_in);
      gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
      gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
            | (gp[2] & gp[1] & gp[0] & c_in);
      gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
            | (gp[3] & gp[2] & gp[1] & gg[0])
            | (gp[3] & gp[2] & gp[1] & gp[0] & c_in);
   end

   // Bit carries inside each group, seeded by the group carry.
   always_comb begin
      c = '0;
      for (int k = 0; k < 4; k++) begin
         c[4*k] = gc[k];
         for (int j = 1; j < 4; j++) begin
            c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
         end
      end
   end

   assign sum   = p ^ c;
   assign c_out = gc[4];

endmodule

module mult_16b_seq #(
   parameter int unsigned N     = 16,
   parameter int unsigned CNT_W = 5
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     mcand_q, mcand_d;
   logic [N-1:0]     hi_q, hi_d;
   logic [N-1:0]     lo_q, lo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2*N-1:0]   product_d;
   logic             busy_d;
   logic             done_d;

   logic [N-1:0]     add_op;
   logic [N-1:0]     sum;
   logic             c_out;

   // Adding zero when the multiplier bit is clear keeps a single adder path.
   assign add_op = lo_q[0] ? mcand_q : '0;

   cla_16b u_cla (
      .a     (hi_q),
      .b     (add_op),
      .c_in  (1'b0),
      .sum   (sum),
      .c_out (c_out)
   );

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
         product <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
         product <= product_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

   // Next state, next datapath values; busy/done are registered from next state.
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      cnt_d     = cnt_q;
      product_d = product;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               mcand_d = a;
               hi_d    = '0;
               lo_d    = b;
               cnt_d   = '0;
               state_d = RUN;
`ifdef ZERO_SKIP_EN
               if ((a == '0) || (b == '0)) begin
                  state_d   = DONE;
                  product_d = '0;
               end
`endif
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            // Carry-out becomes the new MSB of hi, so no product bit is lost.
            {hi_d, lo_d} = {c_out, sum, lo_q[N-1:1]};
            cnt_d        = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N-1)) begin
               state_d   = DONE;
               product_d = {c_out, sum, lo_q[N-1:1]};
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

endmodule
